// File: rtl/router_fsm_if.sv
// Signal bundle between the router packet-reception FSM and its neighbours
// (packet source, synchroniser and register block). The FSM takes the slave
// side; the surrounding logic, or a bench, takes the master side.
interface router_fsm_if;

    // Source and datapath status into the FSM
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;

    // State strobes out of the FSM
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;

    // Raw one-hot state register, for observation only
    logic [7:0] state_dbg;

    // Handshake with the source: data_in is consumed on a rising edge only
    // while busy is low; while busy is high the source must hold data_in and
    // pkt_valid steady. There is no separate ready signal.
    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
        output write_enb_reg, rst_int_reg, busy, state_dbg
    );

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
        input  write_enb_reg, rst_int_reg, busy, state_dbg
    );

endinterface

// File: rtl/router_fsm.sv
// Packet-reception controller for the 1x3 router. Sequences header decode,
// payload load, parity load and FIFO-full stalls, drives the strobes used by
// the synchroniser and register block, and holds off the source via busy.
// Outputs are pure Moore decodes of a one-hot state register.
module router_fsm (
    input  logic        clock,
    input  logic        resetn,
    router_fsm_if.slave bus
);

    // One-hot encoding; any pattern not listed falls into the default arm of
    // the next-state decode and returns to DECODE_ADDRESS on the next edge.
    typedef enum logic [7:0] {
        DECODE_ADDRESS     = 8'b0000_0001,
        LOAD_FIRST_DATA    = 8'b0000_0010,
        LOAD_DATA          = 8'b0000_0100,
        FIFO_FULL_STATE    = 8'b0000_1000,
        LOAD_AFTER_FULL    = 8'b0001_0000,
        LOAD_PARITY        = 8'b0010_0000,
        CHECK_PARITY_ERROR = 8'b0100_0000,
        WAIT_TILL_EMPTY    = 8'b1000_0000
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_addr;

    logic       w_empty_sel;    // empty flag of the latched destination
    logic       w_soft_sel;     // soft reset of the latched destination
    logic       w_empty_hdr;    // empty flag of the port named by data_in
    logic       w_hdr_ok;       // valid header addressing a real port

    // Select empty/soft-reset flags of the latched destination port.
    always_comb begin
        w_empty_sel = 1'b0;
        w_soft_sel  = 1'b0;
        case (r_addr)
            2'd0: begin
                w_empty_sel = bus.fifo_empty_0;
                w_soft_sel  = bus.soft_reset_0;
            end
            2'd1: begin
                w_empty_sel = bus.fifo_empty_1;
                w_soft_sel  = bus.soft_reset_1;
            end
            2'd2: begin
                w_empty_sel = bus.fifo_empty_2;
                w_soft_sel  = bus.soft_reset_2;
            end
            default: begin
                w_empty_sel = 1'b0;
                w_soft_sel  = 1'b0;
            end
        endcase
    end

    // Header-time empty check: the address is not latched yet, so look at
    // the port named directly by data_in.
    always_comb begin
        w_empty_hdr = 1'b0;
        case (bus.data_in)
            2'd0:    w_empty_hdr = bus.fifo_empty_0;
            2'd1:    w_empty_hdr = bus.fifo_empty_1;
            2'd2:    w_empty_hdr = bus.fifo_empty_2;
            default: w_empty_hdr = 1'b0;
        endcase
    end

    assign w_hdr_ok = bus.pkt_valid && (bus.data_in != 2'd3);

    // Latch the destination address whenever a header is presented.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_addr <= 2'd0;
        end else if ((r_state == DECODE_ADDRESS) && bus.pkt_valid) begin
            r_addr <= bus.data_in;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= DECODE_ADDRESS;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; a soft reset on the active port overrides all arcs.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DECODE_ADDRESS: begin
                if (w_hdr_ok) begin
                    if (w_empty_hdr) begin
                        w_next_state = LOAD_FIRST_DATA;
                    end else begin
                        w_next_state = WAIT_TILL_EMPTY;
                    end
                end
            end
            LOAD_FIRST_DATA: begin
                w_next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (bus.fifo_full) begin
                    w_next_state = FIFO_FULL_STATE;
                end else if (!bus.pkt_valid) begin
                    w_next_state = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) begin
                    w_next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done) begin
                    w_next_state = DECODE_ADDRESS;
                end else if (bus.low_pkt_valid) begin
                    w_next_state = LOAD_PARITY;
                end else begin
                    w_next_state = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                w_next_state = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                if (bus.fifo_full) begin
                    w_next_state = FIFO_FULL_STATE;
                end else begin
                    w_next_state = DECODE_ADDRESS;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (w_empty_sel) begin
                    w_next_state = LOAD_FIRST_DATA;
                end
            end
            default: begin
                w_next_state = DECODE_ADDRESS;
            end
        endcase

        if ((r_state != DECODE_ADDRESS) && w_soft_sel) begin
            w_next_state = DECODE_ADDRESS;
        end
    end

    // Moore output decode from the state register only.
    always_comb begin
        bus.detect_add    = 1'b0;
        bus.lfd_state     = 1'b0;
        bus.ld_state      = 1'b0;
        bus.laf_state     = 1'b0;
        bus.full_state    = 1'b0;
        bus.write_enb_reg = 1'b0;
        bus.rst_int_reg   = 1'b0;
        bus.busy          = 1'b0;
        case (r_state)
            DECODE_ADDRESS: begin
                bus.detect_add = 1'b1;
            end
            LOAD_FIRST_DATA: begin
                bus.lfd_state = 1'b1;
                bus.busy      = 1'b1;
            end
            LOAD_DATA: begin
                bus.ld_state      = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                bus.full_state = 1'b1;
                bus.busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                bus.laf_state     = 1'b1;
                bus.write_enb_reg = 1'b1;
                bus.busy          = 1'b1;
            end
            LOAD_PARITY: begin
                bus.write_enb_reg = 1'b1;
                bus.busy          = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                bus.rst_int_reg = 1'b1;
                bus.busy        = 1'b1;
            end
            WAIT_TILL_EMPTY: begin
                bus.busy = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios with literal expectations,
// a short randomised tail, and a packet-phase model compared every cycle.
module tb_router_fsm;

    logic clock;
    logic resetn;
    router_fsm_if bus();

    router_fsm dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output vector order: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
    localparam logic [7:0] V_DEC  = 8'b1000_0000;
    localparam logic [7:0] V_LFD  = 8'b0100_0001;
    localparam logic [7:0] V_LD   = 8'b0010_0100;
    localparam logic [7:0] V_LAF  = 8'b0001_0101;
    localparam logic [7:0] V_FULL = 8'b0000_1001;
    localparam logic [7:0] V_LP   = 8'b0000_0101;
    localparam logic [7:0] V_CPE  = 8'b0000_0011;
    localparam logic [7:0] V_WTE  = 8'b0000_0001;

    // Model packet phases and the outputs each phase must show
    localparam int P_DEC = 0, P_LFD = 1, P_LD = 2, P_FULL = 3,
                   P_LAF = 4, P_LP = 5, P_CPE = 6, P_WTE = 7;
    localparam logic [7:0] EXP_TAB [8] =
        '{V_DEC, V_LFD, V_LD, V_FULL, V_LAF, V_LP, V_CPE, V_WTE};

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    logic [7:0] out_vec;
    assign out_vec = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                      bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    // Behavioural model: tracks where the current packet is, by port number.
    int       m_phase = P_DEC;
    int       m_port  = 0;
    always @(posedge clock or negedge resetn) begin
        logic empty_v [4];
        logic soft_v  [4];
        int   nxt;
        if (!resetn) begin
            m_phase = P_DEC;
            m_port  = 0;
        end else begin
            empty_v = '{bus.fifo_empty_0, bus.fifo_empty_1, bus.fifo_empty_2, 1'b0};
            soft_v  = '{bus.soft_reset_0, bus.soft_reset_1, bus.soft_reset_2, 1'b0};
            nxt = m_phase;
            if (m_phase == P_DEC) begin
                if (bus.pkt_valid && bus.data_in != 2'd3)
                    nxt = empty_v[bus.data_in] ? P_LFD : P_WTE;
                if (bus.pkt_valid) m_port = int'(bus.data_in);
            end else if (soft_v[m_port]) begin
                nxt = P_DEC;
            end else if (m_phase == P_LFD) nxt = P_LD;
            else if (m_phase == P_LD)   nxt = bus.fifo_full ? P_FULL : (!bus.pkt_valid ? P_LP : P_LD);
            else if (m_phase == P_FULL) nxt = bus.fifo_full ? P_FULL : P_LAF;
            else if (m_phase == P_LAF)  nxt = bus.parity_done ? P_DEC : (bus.low_pkt_valid ? P_LP : P_LD);
            else if (m_phase == P_LP)   nxt = P_CPE;
            else if (m_phase == P_CPE)  nxt = bus.fifo_full ? P_FULL : P_DEC;
            else if (m_phase == P_WTE)  nxt = empty_v[m_port] ? P_LFD : P_WTE;
            m_phase = nxt;
        end
    end

    // Compare process: every falling edge, DUT outputs against the model
    always @(negedge clock) begin
        if (cmp_en) chk("model", out_vec, EXP_TAB[m_phase]);
    end

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'd0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty_0  = 1'b1;
        bus.fifo_empty_1  = 1'b1;
        bus.fifo_empty_2  = 1'b1;
        bus.soft_reset_0  = 1'b0;
        bus.soft_reset_1  = 1'b0;
        bus.soft_reset_2  = 1'b0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        #12;
        chk("reset_vec", out_vec, V_DEC);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        cmp_en = 1'b1;

        // idle holds in DECODE_ADDRESS
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_dec", out_vec, V_DEC);
        end

        // normal packet to port 1, 4 payload cycles
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd1;
        step(); chk("p1_lfd", out_vec, V_LFD);
        for (int i = 0; i < 4; i++) begin
            step(); chk("p1_ld", out_vec, V_LD);
        end
        bus.pkt_valid = 1'b0;
        step(); chk("p1_lp", out_vec, V_LP);
        step(); chk("p1_cpe", out_vec, V_CPE);
        step(); chk("p1_dec", out_vec, V_DEC);

        // invalid address 3 is ignored
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd3;
        for (int i = 0; i < 5; i++) begin
            step(); chk("addr3_dec", out_vec, V_DEC);
        end
        bus.pkt_valid = 1'b0;
        step(); chk("addr3_idle", out_vec, V_DEC);

        // port 0 not empty: wait, then proceed once it drains
        bus.pkt_valid    = 1'b1;
        bus.data_in      = 2'd0;
        bus.fifo_empty_0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(); chk("p0_wte", out_vec, V_WTE);
        end
        bus.fifo_empty_0 = 1'b1;
        step(); chk("p0_lfd", out_vec, V_LFD);
        step(); chk("p0_ld", out_vec, V_LD);

        // full stall for 3 cycles, then resume into parity via low_pkt_valid
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("stall_full", out_vec, V_FULL);
        end
        bus.fifo_full     = 1'b0;
        bus.pkt_valid     = 1'b0;
        bus.low_pkt_valid = 1'b1;
        step(); chk("stall_laf", out_vec, V_LAF);
        step(); chk("stall_lp", out_vec, V_LP);
        bus.low_pkt_valid = 1'b0;
        step(); chk("stall_cpe", out_vec, V_CPE);
        step(); chk("stall_dec", out_vec, V_DEC);

        // full wins over pkt_valid fall; then parity_done ends the packet
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd0;
        step(); chk("pd_lfd", out_vec, V_LFD);
        step(); chk("pd_ld", out_vec, V_LD);
        bus.fifo_full = 1'b1;
        bus.pkt_valid = 1'b0;
        step(); chk("pd_full_prio", out_vec, V_FULL);
        bus.fifo_full   = 1'b0;
        bus.parity_done = 1'b1;
        step(); chk("pd_laf", out_vec, V_LAF);
        step(); chk("pd_dec", out_vec, V_DEC);
        bus.parity_done = 1'b0;

        // LAF back to LOAD_DATA, then CPE with FIFO full re-enters the stall
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd1;
        step(); chk("laf_lfd", out_vec, V_LFD);
        step(); chk("laf_ld", out_vec, V_LD);
        bus.fifo_full = 1'b1;
        step(); chk("laf_full", out_vec, V_FULL);
        bus.fifo_full = 1'b0;
        step(); chk("laf_laf", out_vec, V_LAF);
        step(); chk("laf_back_ld", out_vec, V_LD);
        bus.pkt_valid = 1'b0;
        step(); chk("cpe_lp", out_vec, V_LP);
        bus.fifo_full = 1'b1;
        step(); chk("cpe_cpe", out_vec, V_CPE);
        step(); chk("cpe_full", out_vec, V_FULL);
        bus.fifo_full = 1'b0;
        bus.parity_done = 1'b1;
        step(); chk("cpe_laf", out_vec, V_LAF);
        step(); chk("cpe_dec", out_vec, V_DEC);
        bus.parity_done = 1'b0;

        // port 2 packet: foreign soft reset ignored, own soft reset aborts
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd2;
        step(); chk("p2_lfd", out_vec, V_LFD);
        step(); chk("p2_ld", out_vec, V_LD);
        bus.soft_reset_0 = 1'b1;
        step(); chk("p2_sr0_ignored", out_vec, V_LD);
        bus.soft_reset_0 = 1'b0;
        bus.soft_reset_2 = 1'b1;
        step(); chk("p2_sr2_abort", out_vec, V_DEC);
        bus.soft_reset_2 = 1'b0;
        bus.pkt_valid    = 1'b0;
        step(); chk("p2_idle", out_vec, V_DEC);

        // asynchronous reset mid-packet
        bus.pkt_valid = 1'b1;
        step(); chk("ar_lfd", out_vec, V_LFD);
        step(); chk("ar_ld", out_vec, V_LD);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_reset", out_vec, V_DEC);
        bus.pkt_valid = 1'b0;
        step();
        resetn = 1'b1;
        step(); chk("ar_release", out_vec, V_DEC);

        // randomised tail, checked by the model only
        for (int i = 0; i < 400; i++) begin
            bus.pkt_valid     = ($urandom_range(0, 3) != 0);
            bus.data_in       = 2'($urandom_range(0, 3));
            bus.fifo_full     = ($urandom_range(0, 3) == 0);
            bus.fifo_empty_0  = ($urandom_range(0, 2) != 0);
            bus.fifo_empty_1  = ($urandom_range(0, 2) != 0);
            bus.fifo_empty_2  = ($urandom_range(0, 2) != 0);
            bus.soft_reset_0  = ($urandom_range(0, 15) == 0);
            bus.soft_reset_1  = ($urandom_range(0, 15) == 0);
            bus.soft_reset_2  = ($urandom_range(0, 15) == 0);
            bus.parity_done   = ($urandom_range(0, 3) == 0);
            bus.low_pkt_valid = ($urandom_range(0, 2) == 0);
            step();
        end

        idle_inputs();
        step();
        step();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Packet-reception controller for the 1x3 router. It sequences header decode, payload load, parity load and FIFO-full stalls for the three destination FIFOs.
- It drives the strobes consumed by the synchroniser (detect_add, write_enb_reg) and by the register block (lfd_state, ld_state, laf_state, full_state, rst_int_reg).
- It flow-controls the source via busy.
- It recovers from a per-port soft reset raised by the synchroniser.

Parameters:
- None. Three destination ports and the 2-bit address field are fixed by the packet format.

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- pkt_valid  in  1  source packet-valid (high from header through last payload byte)
- data_in  in  2  header address bits data_in[1:0]: 0/1/2 = port, 3 = invalid
- fifo_full  in  1  full flag of the currently addressed FIFO
- fifo_empty_0/1/2  in  1 each  FIFO empty flags
- soft_reset_0/1/2  in  1 each  per-port soft reset from the synchroniser
- parity_done  in  1  register block has loaded the parity byte
- low_pkt_valid  in  1  register block saw pkt_valid fall while stalled
- detect_add  out  1  header decode strobe
- lfd_state  out  1  load-first-data (header write)
- ld_state  out  1  load-payload
- laf_state  out  1  load-after-full (replay held byte)
- full_state  out  1  stalled on FIFO full
- write_enb_reg  out  1  FIFO write request
- rst_int_reg  out  1  parity-check / internal-register clear strobe
- busy  out  1  source must hold data

Behaviour:
- State register
  - 8 states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
  - Updates on the rising edge of clock.
  - resetn low asynchronously forces DECODE_ADDRESS and clears addr_q to 0.
- Address latch
  - Internal addr_q[1:0] captures data_in on the rising edge when state == DECODE_ADDRESS and pkt_valid == 1.
  - addr_q selects empty_sel = fifo_empty_[addr_q] and soft_sel = soft_reset_[addr_q].
  - In DECODE_ADDRESS only, the empty check uses data_in directly, not addr_q.
- Transitions (evaluated each rising edge)
  - DECODE_ADDRESS:
    - pkt_valid & data_in!=3 & fifo_empty_[data_in] → LOAD_FIRST_DATA
    - pkt_valid & data_in!=3 & !fifo_empty_[data_in] → WAIT_TILL_EMPTY
    - otherwise stay; a data_in==3 packet is ignored.
  - LOAD_FIRST_DATA → LOAD_DATA, unconditionally.
  - LOAD_DATA:
    - fifo_full → FIFO_FULL_STATE
    - else !pkt_valid → LOAD_PARITY
    - else stay
    - fifo_full has priority when both conditions hold.
  - FIFO_FULL_STATE: !fifo_full → LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL:
    - parity_done → DECODE_ADDRESS
    - else low_pkt_valid → LOAD_PARITY
    - else → LOAD_DATA
  - LOAD_PARITY → CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full → FIFO_FULL_STATE; else → DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: empty_sel → LOAD_FIRST_DATA; else stay.
- Soft reset
  - soft_sel high in any state other than DECODE_ADDRESS → DECODE_ADDRESS on the next edge.
  - Soft reset overrides every other transition.
  - Soft resets on non-addressed ports are ignored.
- Outputs: Moore, decoded combinationally from state only (no input-to-output paths).
  - detect_add = DECODE_ADDRESS
  - lfd_state = LOAD_FIRST_DATA
  - ld_state = LOAD_DATA
  - full_state = FIFO_FULL_STATE
  - laf_state = LOAD_AFTER_FULL
  - rst_int_reg = CHECK_PARITY_ERROR
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
  - busy = every state except DECODE_ADDRESS and LOAD_DATA
- Reset values (resetn low): detect_add=1; all other outputs 0.
- State encoding is free, but must be one-hot-safe: an illegal state recovers to DECODE_ADDRESS in one cycle.
- Latency
  - Header accepted to first FIFO write: 1 cycle (LOAD_FIRST_DATA).
  - pkt_valid fall to parity write: 1 cycle.
  - Parity write to return to DECODE_ADDRESS: 2 cycles minimum.

Test Plan:
- Reset, then release with pkt_valid=0 → state DECODE_ADDRESS; detect_add=1, busy=0, write_enb_reg=0, all other outputs 0; holds indefinitely.
- Header data_in=2'b01, fifo_empty_1=1, pkt_valid high for 4 payload cycles then low → sequence DECODE_ADDRESS, LOAD_FIRST_DATA(busy=1), LOAD_DATA×4(write_enb_reg=1, busy=0), LOAD_PARITY(write_enb_reg=1, busy=1), CHECK_PARITY_ERROR(rst_int_reg=1), DECODE_ADDRESS.
- data_in=2'b11 with pkt_valid=1 for 5 cycles → stays in DECODE_ADDRESS; write_enb_reg never asserts.
- Header to port 0 with fifo_empty_0=0 → WAIT_TILL_EMPTY, busy=1; fifo_empty_0 rises after 6 cycles → LOAD_FIRST_DATA next edge.
- Full stall in LOAD_DATA: fifo_full=1 for 3 cycles → FIFO_FULL_STATE, full_state=1, write_enb_reg=0; then fifo_full=0 → LOAD_AFTER_FULL; then:
  - low_pkt_valid=1, parity_done=0 → LOAD_PARITY.
  - Repeat with parity_done=1 → DECODE_ADDRESS.
- Port-2 packet in LOAD_DATA:
  - soft_reset_0 pulse → no effect.
  - soft_reset_2 pulse → DECODE_ADDRESS next edge.
  - resetn asserted mid-packet → DECODE_ADDRESS immediately, without waiting for a clock edge.
